// File: rtl/execution_stage_md.sv
// Execution stage: single-cycle ALU/branch path plus an iterative radix-2
// RV32M multiply/divide unit, all results presented through pipeline registers.
module execution_stage_md #(
   parameter int XLEN      = 32,
   parameter bit MD_ENABLE = 1'b1,
   parameter int CNT_W     = $clog2(XLEN) + 1
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            VALID_IN,
   input  logic            STALL_EXECUTION_STAGE,
   input  logic            FLUSH,
   input  logic [XLEN-1:0] PC_IN,
   input  logic [4:0]      RD_ADDRESS_IN,
   input  logic [XLEN-1:0] RS1_DATA,
   input  logic [XLEN-1:0] RS2_DATA,
   input  logic [XLEN-1:0] IMM_DATA,
   input  logic [4:0]      ALU_INSTRUCTION,
   input  logic            ALU_INPUT_1_SELECT,
   input  logic            ALU_INPUT_2_SELECT,
   input  logic [2:0]      DATA_CACHE_LOAD_IN,
   input  logic [1:0]      DATA_CACHE_STORE_IN,
   input  logic [XLEN-1:0] DATA_CACHE_STORE_DATA_IN,
   input  logic            WRITE_BACK_MUX_SELECT_IN,
   input  logic            RD_WRITE_ENABLE_IN,
   output logic            BUSY,
   output logic            VALID_OUT,
   output logic [4:0]      RD_ADDRESS_OUT,
   output logic [XLEN-1:0] ALU_OUT,
   output logic            BRANCH_TAKEN,
   output logic [XLEN-1:0] BRANCH_TARGET_OUT,
   output logic [2:0]      DATA_CACHE_LOAD_OUT,
   output logic [1:0]      DATA_CACHE_STORE_OUT,
   output logic [XLEN-1:0] DATA_CACHE_STORE_DATA_OUT,
   output logic            WRITE_BACK_MUX_SELECT_OUT,
   output logic            RD_WRITE_ENABLE_OUT
);

   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [2:0]        md_op_q, md_op_d;
   logic              neg_q, neg_d, div_zero_q, div_zero_d;

   logic [4:0]        lat_rd_q, lat_rd_d;
   logic [2:0]        lat_ld_q, lat_ld_d;
   logic [1:0]        lat_st_q, lat_st_d;
   logic [XLEN-1:0]   lat_sd_q, lat_sd_d, lat_tgt_q, lat_tgt_d;
   logic              lat_wb_q, lat_wb_d, lat_we_q, lat_we_d;

   logic              valid_q, valid_d, taken_q, taken_d, wb_q, wb_d, we_q, we_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   alu_q, alu_d, tgt_q, tgt_d, sd_q, sd_d;
   logic [2:0]        ld_q, ld_d;
   logic [1:0]        st_q, st_d;

   logic [XLEN-1:0]   op_a, op_b, target, sc_result;
   logic [SH_W-1:0]   shamt;
   logic              sc_taken, is_branch, is_md_op;

   assign op_a      = ALU_INPUT_1_SELECT ? PC_IN : RS1_DATA;
   assign op_b      = ALU_INPUT_2_SELECT ? IMM_DATA : RS2_DATA;
   assign shamt     = op_b[SH_W-1:0];
   assign target    = PC_IN + IMM_DATA;
   assign is_branch = (ALU_INSTRUCTION >= 5'd10) && (ALU_INSTRUCTION <= 5'd15);
   assign is_md_op  = MD_ENABLE && (ALU_INSTRUCTION[4:3] == 2'b10);

   always_comb begin
      sc_result = '0;
      sc_taken  = 1'b0;
      case (ALU_INSTRUCTION)
         5'd0:  sc_result = op_a + op_b;
         5'd1:  sc_result = op_a - op_b;
         5'd2:  sc_result = op_a << shamt;
         5'd3:  sc_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         5'd4:  sc_result = {{(XLEN-1){1'b0}}, op_a < op_b};
         5'd5:  sc_result = op_a ^ op_b;
         5'd6:  sc_result = op_a >> shamt;
         5'd7:  sc_result = $unsigned($signed(op_a) >>> shamt);
         5'd8:  sc_result = op_a | op_b;
         5'd9:  sc_result = op_a & op_b;
         5'd10: sc_taken  = RS1_DATA == RS2_DATA;
         5'd11: sc_taken  = RS1_DATA != RS2_DATA;
         5'd12: sc_taken  = $signed(RS1_DATA) < $signed(RS2_DATA);
         5'd13: sc_taken  = $signed(RS1_DATA) >= $signed(RS2_DATA);
         5'd14: sc_taken  = RS1_DATA < RS2_DATA;
         5'd15: sc_taken  = RS1_DATA >= RS2_DATA;
         default: ;
      endcase
      if (is_branch) sc_result = target;
   end

   // Iterative unit works on magnitudes; signs are folded back in once at DONE.
   logic            sign_a, sign_b, sa, sb;
   logic [XLEN-1:0] mag_a, mag_b;

   assign sign_a = (ALU_INSTRUCTION[2:0] == 3'd1) || (ALU_INSTRUCTION[2:0] == 3'd2) ||
                   (ALU_INSTRUCTION[2:0] == 3'd4) || (ALU_INSTRUCTION[2:0] == 3'd6);
   assign sign_b = (ALU_INSTRUCTION[2:0] == 3'd1) || (ALU_INSTRUCTION[2:0] == 3'd4) ||
                   (ALU_INSTRUCTION[2:0] == 3'd6);
   assign sa     = sign_a & op_a[XLEN-1];
   assign sb     = sign_b & op_b[XLEN-1];
   assign mag_a  = sa ? -op_a : op_a;
   assign mag_b  = sb ? -op_b : op_b;

   logic [XLEN:0]     mul_sum, div_r;
   logic [XLEN-1:0]   div_diff, quo_s, rem_s, md_result;
   logic [2*XLEN-1:0] prod_s;
   logic              div_ge;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign div_r    = {hi_q, lo_q[XLEN-1]};
   assign div_ge   = div_r >= {1'b0, opnd_q};
   assign div_diff = div_r[XLEN-1:0] - opnd_q;

   assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign quo_s  = div_zero_q ? '1 : (neg_q ? -lo_q : lo_q);
   assign rem_s  = neg_q ? -hi_q : hi_q;

   always_comb begin
      case (md_op_q)
         3'd0:          md_result = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: md_result = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:    md_result = quo_s;
         default:       md_result = rem_s;
      endcase
   end

   // Sequencing: accept/latch in IDLE, XLEN steps in CALC, sign fix-up and drain in DONE.
   logic bubble;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      opnd_d     = opnd_q;
      md_op_d    = md_op_q;
      neg_d      = neg_q;
      div_zero_d = div_zero_q;
      lat_rd_d   = lat_rd_q;
      lat_ld_d   = lat_ld_q;
      lat_st_d   = lat_st_q;
      lat_sd_d   = lat_sd_q;
      lat_tgt_d  = lat_tgt_q;
      lat_wb_d   = lat_wb_q;
      lat_we_d   = lat_we_q;
      valid_d    = valid_q;
      rd_d       = rd_q;
      alu_d      = alu_q;
      taken_d    = taken_q;
      tgt_d      = tgt_q;
      ld_d       = ld_q;
      st_d       = st_q;
      sd_d       = sd_q;
      wb_d       = wb_q;
      we_d       = we_q;
      bubble     = 1'b0;

      if (FLUSH) begin
         state_d = IDLE;
         cnt_d   = '0;
         bubble  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!STALL_EXECUTION_STAGE) begin
                  if (VALID_IN && is_md_op) begin
                     state_d    = CALC;
                     cnt_d      = '0;
                     hi_d       = '0;
                     lo_d       = ALU_INSTRUCTION[2] ? mag_a : mag_b;
                     opnd_d     = ALU_INSTRUCTION[2] ? mag_b : mag_a;
                     md_op_d    = ALU_INSTRUCTION[2:0];
                     neg_d      = (ALU_INSTRUCTION[2:1] == 2'b11) ? sa : (sa ^ sb);
                     div_zero_d = (op_b == '0);
                     lat_rd_d   = RD_ADDRESS_IN;
                     lat_ld_d   = DATA_CACHE_LOAD_IN;
                     lat_st_d   = DATA_CACHE_STORE_IN;
                     lat_sd_d   = DATA_CACHE_STORE_DATA_IN;
                     lat_tgt_d  = target;
                     lat_wb_d   = WRITE_BACK_MUX_SELECT_IN;
                     lat_we_d   = RD_WRITE_ENABLE_IN;
                     bubble     = 1'b1;
                  end else if (VALID_IN) begin
                     valid_d = 1'b1;
                     rd_d    = RD_ADDRESS_IN;
                     alu_d   = sc_result;
                     taken_d = sc_taken;
                     tgt_d   = target;
                     ld_d    = DATA_CACHE_LOAD_IN;
                     st_d    = DATA_CACHE_STORE_IN;
                     sd_d    = DATA_CACHE_STORE_DATA_IN;
                     wb_d    = WRITE_BACK_MUX_SELECT_IN;
                     we_d    = RD_WRITE_ENABLE_IN;
                  end else begin
                     bubble = 1'b1;
                  end
               end
            end
            CALC: begin
               if (md_op_q[2]) begin
                  hi_d = div_ge ? div_diff : div_r[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ge};
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
            end
            DONE: begin
               if (!STALL_EXECUTION_STAGE) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  rd_d    = lat_rd_q;
                  alu_d   = md_result;
                  taken_d = 1'b0;
                  tgt_d   = lat_tgt_q;
                  ld_d    = lat_ld_q;
                  st_d    = lat_st_q;
                  sd_d    = lat_sd_q;
                  wb_d    = lat_wb_q;
                  we_d    = lat_we_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (bubble) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
         taken_d = 1'b0;
         st_d    = '0;
         ld_d    = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         opnd_q     <= '0;
         md_op_q    <= '0;
         neg_q      <= 1'b0;
         div_zero_q <= 1'b0;
         lat_rd_q   <= '0;
         lat_ld_q   <= '0;
         lat_st_q   <= '0;
         lat_sd_q   <= '0;
         lat_tgt_q  <= '0;
         lat_wb_q   <= 1'b0;
         lat_we_q   <= 1'b0;
         valid_q    <= 1'b0;
         rd_q       <= '0;
         alu_q      <= '0;
         taken_q    <= 1'b0;
         tgt_q      <= '0;
         ld_q       <= '0;
         st_q       <= '0;
         sd_q       <= '0;
         wb_q       <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         opnd_q     <= opnd_d;
         md_op_q    <= md_op_d;
         neg_q      <= neg_d;
         div_zero_q <= div_zero_d;
         lat_rd_q   <= lat_rd_d;
         lat_ld_q   <= lat_ld_d;
         lat_st_q   <= lat_st_d;
         lat_sd_q   <= lat_sd_d;
         lat_tgt_q  <= lat_tgt_d;
         lat_wb_q   <= lat_wb_d;
         lat_we_q   <= lat_we_d;
         valid_q    <= valid_d;
         rd_q       <= rd_d;
         alu_q      <= alu_d;
         taken_q    <= taken_d;
         tgt_q      <= tgt_d;
         ld_q       <= ld_d;
         st_q       <= st_d;
         sd_q       <= sd_d;
         wb_q       <= wb_d;
         we_q       <= we_d;
      end
   end

   assign BUSY                      = (state_q != IDLE);
   assign VALID_OUT                 = valid_q;
   assign RD_ADDRESS_OUT            = rd_q;
   assign ALU_OUT                   = alu_q;
   assign BRANCH_TAKEN              = taken_q;
   assign BRANCH_TARGET_OUT         = tgt_q;
   assign DATA_CACHE_LOAD_OUT       = ld_q;
   assign DATA_CACHE_STORE_OUT      = st_q;
   assign DATA_CACHE_STORE_DATA_OUT = sd_q;
   assign WRITE_BACK_MUX_SELECT_OUT = wb_q;
   assign RD_WRITE_ENABLE_OUT       = we_q;

endmodule

// File: doc/execution_stage_md.md
Name: execution_stage_md

Overview:
Parametrised successor to the single-cycle execution stage. Combines the single-cycle ALU/branch path with an iterative RV32M multiply/divide unit, one bit per cycle, and pipeline-register outputs. Sits between the decode stage and the data-cache stage. It raises BUSY to stall upstream while a multiply/divide is in flight, and honours downstream STALL and FLUSH.

Parameters:
XLEN, 32, datapath width (≥8, even)
MD_ENABLE, 1, 1 = implement ops 16-23; 0 = ops 16-23 return 0 in one cycle
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
VALID_IN  in  1  decode presents an instruction
STALL_EXECUTION_STAGE  in  1  downstream stall; output registers hold
FLUSH  in  1  synchronous kill of in-flight and accepted work
PC_IN  in  XLEN  instruction PC
RD_ADDRESS_IN  in  5  destination register
RS1_DATA, RS2_DATA, IMM_DATA  in  XLEN each  operands
ALU_INSTRUCTION  in  5  op code (see Behaviour)
ALU_INPUT_1_SELECT  in  1  0 = RS1, 1 = PC
ALU_INPUT_2_SELECT  in  1  0 = RS2, 1 = IMM
DATA_CACHE_LOAD_IN  in  3; DATA_CACHE_STORE_IN  in  2; DATA_CACHE_STORE_DATA_IN  in  XLEN; WRITE_BACK_MUX_SELECT_IN  in  1; RD_WRITE_ENABLE_IN  in  1  passed through
BUSY  out  1  combinational: state != IDLE
VALID_OUT  out  1  output registers hold a real instruction
RD_ADDRESS_OUT  out  5; ALU_OUT  out  XLEN; BRANCH_TAKEN  out  1; BRANCH_TARGET_OUT  out  XLEN
DATA_CACHE_LOAD_OUT  out  3; DATA_CACHE_STORE_OUT  out  2; DATA_CACHE_STORE_DATA_OUT  out  XLEN; WRITE_BACK_MUX_SELECT_OUT  out  1; RD_WRITE_ENABLE_OUT  out  1

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, counter 0, internal operands 0.
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - 24-31 give result 0 in one cycle.
- Operands: A = sel1 ? PC_IN : RS1_DATA; B = sel2 ? IMM_DATA : RS2_DATA.
  - Shift amount is B[log2(XLEN)-1:0].
  - Branch compares always use RS1_DATA vs RS2_DATA.
  - For branches, ALU_OUT = PC_IN + IMM_DATA.
  - BRANCH_TARGET_OUT = PC_IN + IMM_DATA for every op; BRANCH_TAKEN = 0 for non-branch ops.
  - All sums are modulo 2^XLEN.
- Accept condition: VALID_IN & ~STALL & ~FLUSH & state==IDLE.
- FSM:
  - IDLE:
    - Accepted single-cycle op: all output registers load on the same edge; VALID_OUT=1 (latency 1 edge).
    - Accepted M-op: latch operands, signs, op and sideband; go to CALC with count=0; output registers load a bubble.
    - No accept and no stall: bubble.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per edge on magnitudes; count++. When count reaches XLEN-1, the next edge goes to DONE. Downstream stall does not pause iteration.
  - DONE: sign correction and result selection happen here. If ~STALL, load output registers with result and latched sideband, VALID_OUT=1, go to IDLE. If STALL, hold in DONE.
  - Total: result visible XLEN+1 edges after the accepting edge when unstalled. BUSY is high for those XLEN+1 cycles.
- Bubble: VALID_OUT, RD_WRITE_ENABLE_OUT, BRANCH_TAKEN and DATA_CACHE_STORE_OUT/LOAD_OUT go to 0; other outputs hold.
- Stall in IDLE: all output registers hold; VALID_IN is ignored.
- FLUSH (priority over stall and accept): state goes to IDLE, counter 0, output registers take a bubble.
- Divide special cases:
  - Divisor 0: quotient all ones, remainder = dividend.
  - Signed most-negative / -1: quotient = dividend, remainder 0.
  - Both cases still take the full XLEN+1 latency.
- MULHSU: rs1 is signed, rs2 is unsigned. The product is 2·XLEN bits; MUL returns the low half, MULH* return the high half.
- While BUSY, upstream must hold its inputs; VALID_IN is not sampled.

Test Plan:
1. rs1=2, rs2=1, op 0 (ADD), VALID_IN=1 -> next edge ALU_OUT=3, VALID_OUT=1, BUSY stays 0; op 1 (SUB) gives 1.
2. op 21 (DIVU), 100/7, XLEN=32 -> BUSY high 33 cycles, ALU_OUT=14 on the 33rd edge; REMU gives 2; DIV -7/2 gives 0xFFFFFFFD, REM gives 0xFFFFFFFF.
3. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
4. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULH -1*-1 -> 0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; BEQ rs1=rs2=5, PC=0x100, imm=8 -> BRANCH_TAKEN=1, target 0x108.
5. STALL asserted from cycle 20 of a DIVU through cycle 40 -> stays in DONE, outputs hold old values; result appears one edge after stall drops. FLUSH at cycle 10 of a DIVU -> BUSY=0 next cycle, VALID_OUT=0, RD_WRITE_ENABLE_OUT=0.
6. RESET_N pulled low mid-CALC, asynchronously between edges -> all outputs 0 and BUSY=0 immediately; a new ADD is accepted on the first edge after release.
